// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle MULT/MULTU/DIV/DIVU and MTHI/MTLO unit owning HI/LO; ports: clk, rst, flush, start, op, operand_a, operand_b -> busy, stall_for_mul_cycle, done, hi_o, lo_o
module ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             stall_for_mul_cycle,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  typedef enum logic [1:0] {IDLE, MUL, DIV_ITER, DIV_FIX} state_t;
  localparam int CW = $clog2(WIDTH + MUL_STAGES + 1);
  localparam int MC = MUL_STAGES > 1 ? MUL_STAGES - 2 : 0;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, rem, quo, dvs, a_raw, a_abs, b_abs;
  logic sgn, q_neg, r_neg, dz, done_q, acc, is_mul, is_div;
  logic [2*WIDTH-1:0] div_init;
  function automatic logic [2*WIDTH-1:0] prod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    logic [2*WIDTH-1:0] xe, ye;
    xe = {{WIDTH{s & x[WIDTH-1]}}, x};
    ye = {{WIDTH{s & y[WIDTH-1]}}, y};
    return xe * ye;
  endfunction
  // One restoring step: shift the next dividend bit into the partial remainder.
  // The remainder always stays below the divisor, so WIDTH bits suffice after subtracting.
  function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] d);
    logic [WIDTH:0] t;
    logic ge;
    t = {r, q[WIDTH-1]};
    ge = t >= {1'b0, d};
    return {ge ? t[WIDTH-1:0] - d : t[WIDTH-1:0], q[WIDTH-2:0], ge};
  endfunction
  assign acc = start & ~flush & (state == IDLE);
  assign is_mul = (op == 3'd1) | (op == 3'd2);
  assign is_div = (op == 3'd3) | (op == 3'd4);
  assign a_abs = (op == 3'd3 && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign b_abs = (op == 3'd3 && operand_b[WIDTH-1]) ? -operand_b : operand_b;
  // The first quotient bit is produced on the accept edge so the divide
  // finishes WIDTH+1 cycles after acceptance including the sign-fix cycle.
  assign div_init = step('0, a_abs, b_abs);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = (acc & is_div) ? DIV_ITER : (acc & is_mul & (MUL_STAGES > 1)) ? MUL : IDLE;
      MUL:      state_n = (cnt == '0) ? IDLE : MUL;
      DIV_ITER: state_n = (cnt == '0) ? DIV_FIX : DIV_ITER;
      default:  state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    stall_for_mul_cycle = (acc & (is_mul | is_div)) | busy;
    done = done_q;
    hi_o = hi;
    lo_o = lo;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      a_raw <= '0;
      {sgn, q_neg, r_neg, dz, done_q} <= '0;
    end else begin
      done_q <= ~flush & (((state == MUL) & (cnt == '0)) | (state == DIV_FIX) | (acc & is_mul & (MUL_STAGES == 1)));
      if (acc & (op == 3'd5)) hi <= operand_a;
      if (acc & (op == 3'd6)) lo <= operand_a;
      if (acc & is_mul) begin
        quo <= operand_a;
        dvs <= operand_b;
        sgn <= op == 3'd1;
        cnt <= CW'(MC);
        if (MUL_STAGES == 1) {hi, lo} <= prod(operand_a, operand_b, op == 3'd1);
      end
      if (acc & is_div) begin
        {rem, quo} <= div_init;
        dvs <= b_abs;
        a_raw <= operand_a;
        dz <= operand_b == '0;
        q_neg <= (op == 3'd3) & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
        r_neg <= (op == 3'd3) & operand_a[WIDTH-1];
        cnt <= CW'(WIDTH - 2);
      end
      if (~flush & (state == MUL)) begin
        cnt <= cnt - CW'(1);
        if (cnt == '0) {hi, lo} <= prod(quo, dvs, sgn);
      end
      if (~flush & (state == DIV_ITER)) begin
        {rem, quo} <= step(rem, quo, dvs);
        cnt <= cnt - CW'(1);
      end
      if (~flush & (state == DIV_FIX)) begin
        hi <= dz ? a_raw : r_neg ? -rem : rem;
        lo <= dz ? '1 : q_neg ? -quo : quo;
      end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: table-driven scoreboard bench for ex_muldiv (WIDTH=32, MUL_STAGES=2)
module tb_ex_muldiv;
  logic clk = 0, rst = 1, flush = 0, start = 0;
  logic [2:0] op = 0;
  logic [31:0] operand_a = 0, operand_b = 0;
  logic busy, stall_for_mul_cycle, done;
  logic [31:0] hi_o, lo_o;
  int checks = 0, failures = 0;
  logic [31:0] cur_hi = 0, cur_lo = 0;
  typedef struct {logic [2:0] op; logic [31:0] a, b, hi, lo; int lat;} vec_t;
  typedef struct {logic [31:0] hi, lo; int lat;} exp_t;
  vec_t vecs[10];
  exp_t exp_q[$];
  ex_muldiv #(.WIDTH(32), .MUL_STAGES(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .busy(busy),
    .stall_for_mul_cycle(stall_for_mul_cycle), .done(done), .hi_o(hi_o), .lo_o(lo_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input vec_t v);
    exp_t e;
    int n, stalls;
    logic held;
    op = v.op;
    operand_a = v.a;
    operand_b = v.b;
    start = 1;
    exp_q.push_back('{v.hi, v.lo, v.lat});
    #1;
    chk("stall_accept", stall_for_mul_cycle, 1);
    stalls = 1;
    held = 1;
    tick();
    start = 0;
    n = 1;
    while (!done && n < 200) begin
      if (stall_for_mul_cycle) stalls++;
      if (hi_o !== cur_hi || lo_o !== cur_lo) held = 0;
      tick();
      n++;
    end
    chk("done_seen", done, 1);
    if (done) begin
      e = exp_q.pop_front();
      chk("latency", n, e.lat);
      chk("stall_cycles", stalls, e.lat);
      chk("stall_at_done", stall_for_mul_cycle, 0);
      chk("hilo_held", held, 1);
      chk("hi", hi_o, e.hi);
      chk("lo", lo_o, e.lo);
      cur_hi = e.hi;
      cur_lo = e.lo;
    end
    tick();
    chk("done_pulse", done, 0);
  endtask
  initial begin
    int n, dones;
    vecs[0] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2};
    vecs[1] = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 2};
    vecs[2] = '{3'd1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 2};
    vecs[3] = '{3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 33};
    vecs[4] = '{3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[5] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33};
    vecs[6] = '{3'd4, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 33};
    vecs[7] = '{3'd3, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 33};
    vecs[8] = '{3'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33};
    vecs[9] = '{3'd4, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, 33};
    tick();
    tick();
    rst = 0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall_for_mul_cycle, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i]);
      if (i == 1) begin
        op = 3'd5;
        operand_a = 32'h12345678;
        start = 1;
        #1;
        chk("mthi_stall", stall_for_mul_cycle, 0);
        tick();
        start = 0;
        chk("mthi_hi", hi_o, 32'h12345678);
        chk("mthi_lo", lo_o, cur_lo);
        chk("mthi_done", done, 0);
        chk("mthi_busy", busy, 0);
        cur_hi = 32'h12345678;
      end
    end
    // back-to-back acceptance in the done cycle
    op = 3'd2;
    operand_a = 32'd3;
    operand_b = 32'd5;
    start = 1;
    tick();
    start = 0;
    tick();
    chk("b2b_done1", done, 1);
    chk("b2b_lo1", lo_o, 32'd15);
    chk("b2b_hi1", hi_o, 32'd0);
    op = 3'd1;
    operand_a = 32'hFFFFFFFE;
    operand_b = 32'hFFFFFFFD;
    start = 1;
    #1;
    chk("b2b_stall", stall_for_mul_cycle, 1);
    tick();
    start = 0;
    chk("b2b_busy", busy, 1);
    tick();
    chk("b2b_done2", done, 1);
    chk("b2b_lo2", lo_o, 32'd6);
    op = 3'd6;
    operand_a = 32'hAA;
    start = 1;
    #1;
    chk("b2b_mt_stall", stall_for_mul_cycle, 0);
    tick();
    start = 0;
    chk("b2b_mtlo", lo_o, 32'hAA);
    chk("b2b_mt_done", done, 0);
    cur_hi = 0;
    cur_lo = 32'hAA;
    // flush mid-divide, with a colliding MTLO
    op = 3'd3;
    operand_a = 32'd1000;
    operand_b = 32'd3;
    start = 1;
    tick();
    start = 0;
    repeat (9) tick();
    chk("flush_pre_busy", busy, 1);
    flush = 1;
    start = 1;
    op = 3'd6;
    operand_a = 32'hDEAD;
    tick();
    flush = 0;
    start = 0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_stall", stall_for_mul_cycle, 0);
    chk("flush_hi", hi_o, cur_hi);
    chk("flush_lo", lo_o, cur_lo);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dones++;
    end
    chk("flush_no_done", dones, 0);
    chk("flush_lo_after", lo_o, cur_lo);
    // reset mid-divide while EX keeps start asserted
    op = 3'd4;
    operand_a = 32'd100;
    operand_b = 32'd7;
    start = 1;
    repeat (5) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_hi", hi_o, 0);
    chk("mrst_lo", lo_o, 0);
    chk("mrst_reaccept", stall_for_mul_cycle, 1);
    tick();
    start = 0;
    chk("mrst_busy2", busy, 1);
    n = 1;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("mrst_latency", n, 33);
    chk("mrst_lo2", lo_o, 32'd14);
    chk("mrst_hi2", hi_o, 32'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
